decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
Registered, parametrised successor to the combinational ALU controller for the ri5cy frontend.
- Decodes RV32I OP and OP-IMM instructions, plus LUI, into ALU control, immediate, register addresses and write-enable.
- Adds a valid/ready handshake with a single output pipeline register, illegal-instruction detection and flush.
- Sits between fetch and the execute stage/ALU.

Parameters:
- WORD_WIDTH, 32, instruction and immediate width; must be 32.
- ALU_OP_WIDTH, 4, width of alu_op_ctrl_o.
- MUL_LATENCY, 3, execute cycles for a MUL-class op; range 1..15. Used only with MUL_EXT_EN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous pipeline flush.
- instr_i  in  WORD_WIDTH  instruction word.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  block can accept an instruction this cycle.
- dec_valid_o  out  1  decoded outputs are valid.
- dec_ready_i  in  1  execute stage consumes the decoded outputs.
- alu_op_ctrl_o  out  ALU_OP_WIDTH  ALU operation.
- neg_mux_ctrl_o  out  1  operand-B negate select; 1 only for SUB.
- imm_sel_o  out  1  operand B is the immediate, not rs2.
- imm_o  out  WORD_WIDTH  sign-extended I-immediate, or U-immediate for LUI.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register indices.
- regwrite_en_o  out  1  write rd.
- illegal_instr_o  out  1  instruction not decodable.

Behaviour:
- Reset values: all outputs 0; instr_ready_o is 0 during reset and 1 in the first cycle after reset release.
- ALU op encoding: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10.
- Opcode decode:
  - OP (0110011): funct3/funct7 map to ALU ops per RV32I. funct7 bit 30 selects SUB (funct3=000) and SRA (funct3=101).
  - OP-IMM (0010011): imm_sel_o=1. funct3=000 is always ADD; there is no SUBI.
  - SLLI/SRLI/SRAI: funct7 must be 0000000, or 0100000 for SRAI only.
  - LUI (0110111): ADD with rs1_addr_o forced to 0, imm_o = {instr[31:12], 12'b0}.
  - Any other opcode, funct3 or funct7 combination: illegal_instr_o=1, regwrite_en_o=0, alu_op_ctrl_o=ADD.
- regwrite_en_o = 1 for every legal instruction whose rd is nonzero; 0 when rd=x0.
- Handshake:
  - Accept occurs when instr_valid_i && instr_ready_o. On accept, all decoded fields are registered and dec_valid_o=1 on the next cycle. Latency is 1 cycle.
  - instr_ready_o = (!dec_valid_o || dec_ready_i) && (busy_cnt == 0). This is combinational from dec_ready_i.
  - While dec_valid_o=1 and dec_ready_i=0, all outputs hold stable.
  - Simultaneous consume and accept in the same cycle: the register reloads with the new instruction, giving back-to-back throughput of 1 instruction per cycle.
  - Consume with no accept: dec_valid_o drops to 0 and the data fields hold their last value.
- flush_i: dec_valid_o cleared, busy_cnt cleared, and any same-cycle accept is discarded. flush_i has priority over every other event.
- Reset mid-operation clears dec_valid_o and busy_cnt immediately, without waiting for a clock edge.
- An illegal instruction is still passed downstream with dec_valid_o=1; it does not stall the block.

Optional Feature:
Macro MUL_EXT_EN.
- Defined:
  - OP with funct7=0000001 and funct3=000 decodes to MUL.
  - Accepting a MUL loads a 4-bit busy_cnt with MUL_LATENCY-1. busy_cnt decrements by 1 per cycle down to 0.
  - instr_ready_o stays 0 while busy_cnt is nonzero. dec_valid_o behaves normally.
  - With MUL_LATENCY=1 there is no stall.
- Undefined: funct7=0000001 is illegal, and busy_cnt is not synthesised (the busy_cnt term of instr_ready_o is constant 1).

Test Plan:
1. Reset sequence: rst_ni low, then release -> all outputs 0 during reset; instr_ready_o=1 on the first post-reset cycle.
2. ADD x3,x1,x2 (0x002081B3) accepted at cycle N -> at N+1: dec_valid_o=1, alu_op=0, rd=3, rs1=1, rs2=2, regwrite_en=1, imm_sel=0. Then SUB (0x402081B3) -> alu_op=1, neg_mux=1.
3. ADDI x5,x0,-1 (0xFFF00293) -> imm_o=0xFFFFFFFF, imm_sel=1. SRAI x5,x5,3 (0x4032D293) -> alu_op=7. Opcode 0x0000007F -> illegal_instr_o=1, regwrite_en=0.
4. Backpressure: dec_ready_i=0 for 3 cycles with instr_valid_i=1 -> instr_ready_o=0 and outputs stable. Then dec_ready_i=1 -> one instruction per cycle streams with no gap.
5. flush_i asserted in the same cycle as an accept -> dec_valid_o=0 next cycle and the instruction is dropped. ADD x0,x1,x2 -> regwrite_en=0.
6. (MUL_EXT_EN, MUL_LATENCY=3) MUL x3,x1,x2 (0x022081B3) -> alu_op=10; instr_ready_o=0 for exactly 2 cycles after the accept. Without the macro, the same word -> illegal_instr_o=1.

Source files
------------

// File: rtl/decode_ctrl_pipe_if.sv
// Fetch-to-execute bus for decode_ctrl_pipe: instruction handshake in, decoded control out.
interface decode_ctrl_pipe_if #(
  parameter int WORD_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
);
  logic                    flush_i;
  logic [WORD_WIDTH-1:0]   instr_i;
  logic                    instr_valid_i;
  logic                    instr_ready_o;
  logic                    dec_valid_o;
  logic                    dec_ready_i;
  logic [ALU_OP_WIDTH-1:0] alu_op_ctrl_o;
  logic                    neg_mux_ctrl_o;
  logic                    imm_sel_o;
  logic [WORD_WIDTH-1:0]   imm_o;
  logic [4:0]              rs1_addr_o;
  logic [4:0]              rs2_addr_o;
  logic [4:0]              rd_addr_o;
  logic                    regwrite_en_o;
  logic                    illegal_instr_o;

  modport slave (
    input  flush_i, instr_i, instr_valid_i, dec_ready_i,
    output instr_ready_o, dec_valid_o, alu_op_ctrl_o, neg_mux_ctrl_o, imm_sel_o,
           imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, regwrite_en_o, illegal_instr_o
  );

  modport master (
    output flush_i, instr_i, instr_valid_i, dec_ready_i,
    input  instr_ready_o, dec_valid_o, alu_op_ctrl_o, neg_mux_ctrl_o, imm_sel_o,
           imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, regwrite_en_o, illegal_instr_o
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32I OP/OP-IMM/LUI decoder with valid/ready output stage and flush.
// Optional macro MUL_EXT_EN adds MUL decode plus a multi-cycle busy stall.
module decode_ctrl_pipe #(
  parameter int WORD_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int MUL_LATENCY  = 3
) (
  input logic               clk_i,
  input logic               rst_ni,
  decode_ctrl_pipe_if.slave bus
);

  if (WORD_WIDTH != 32) begin : g_bad_width
    $error("decode_ctrl_pipe: WORD_WIDTH must be 32");
  end
  if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_latency
    $error("decode_ctrl_pipe: MUL_LATENCY must be in 1..15");
  end

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(9);
`ifdef MUL_EXT_EN
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL  = ALU_OP_WIDTH'(10);
`endif

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign opcode   = bus.instr_i[6:0];
  assign rd_field = bus.instr_i[11:7];
  assign funct3   = bus.instr_i[14:12];
  assign funct7   = bus.instr_i[31:25];

  logic [ALU_OP_WIDTH-1:0] alu_op_next;
  logic                    neg_mux_next;
  logic                    imm_sel_next;
  logic [WORD_WIDTH-1:0]   imm_next;
  logic [4:0]              rs1_next;
  logic                    regwrite_next;
  logic                    illegal_next;
  logic                    is_mul_next;

  always_comb begin
    alu_op_next   = ALU_ADD;
    neg_mux_next  = 1'b0;
    imm_sel_next  = 1'b0;
    imm_next      = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
    rs1_next      = bus.instr_i[19:15];
    illegal_next  = 1'b0;
    is_mul_next   = 1'b0;
    regwrite_next = 1'b0;

    case (opcode)
      OPC_OP: begin
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  alu_op_next = ALU_ADD;
              3'b001:  alu_op_next = ALU_SLL;
              3'b010:  alu_op_next = ALU_SLT;
              3'b011:  alu_op_next = ALU_SLTU;
              3'b100:  alu_op_next = ALU_XOR;
              3'b101:  alu_op_next = ALU_SRL;
              3'b110:  alu_op_next = ALU_OR;
              default: alu_op_next = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              alu_op_next  = ALU_SUB;
              neg_mux_next = 1'b1;
            end else if (funct3 == 3'b101) begin
              alu_op_next = ALU_SRA;
            end else begin
              illegal_next = 1'b1;
            end
          end
`ifdef MUL_EXT_EN
          7'b0000001: begin
            if (funct3 == 3'b000) begin
              alu_op_next = ALU_MUL;
              is_mul_next = 1'b1;
            end else begin
              illegal_next = 1'b1;
            end
          end
`endif
          default: illegal_next = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        imm_sel_next = 1'b1;
        case (funct3)
          3'b000: alu_op_next = ALU_ADD;
          3'b010: alu_op_next = ALU_SLT;
          3'b011: alu_op_next = ALU_SLTU;
          3'b100: alu_op_next = ALU_XOR;
          3'b110: alu_op_next = ALU_OR;
          3'b111: alu_op_next = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) alu_op_next = ALU_SLL;
            else                      illegal_next = 1'b1;
          end
          default: begin
            // funct3=101: the shamt field's upper bits pick SRLI vs SRAI
            if (funct7 == 7'b0000000)      alu_op_next = ALU_SRL;
            else if (funct7 == 7'b0100000) alu_op_next = ALU_SRA;
            else                           illegal_next = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        imm_sel_next = 1'b1;
        rs1_next     = 5'd0;
        imm_next     = {bus.instr_i[31:12], 12'b0};
      end
      default: illegal_next = 1'b1;
    endcase

    if (illegal_next) begin
      alu_op_next  = ALU_ADD;
      neg_mux_next = 1'b0;
      is_mul_next  = 1'b0;
    end
    regwrite_next = !illegal_next && (rd_field != 5'd0);
  end

  logic                    dec_valid_reg;
  logic [ALU_OP_WIDTH-1:0] alu_op_reg;
  logic                    neg_mux_reg;
  logic                    imm_sel_reg;
  logic [WORD_WIDTH-1:0]   imm_reg;
  logic [4:0]              rs1_reg;
  logic [4:0]              rs2_reg;
  logic [4:0]              rd_reg;
  logic                    regwrite_reg;
  logic                    illegal_reg;
  logic                    busy_free;
  logic                    instr_ready;
  logic                    accept;

  // Ready is gated by rst_ni so it reads 0 throughout reset, not just after an edge.
  assign instr_ready = rst_ni && (!dec_valid_reg || bus.dec_ready_i) && busy_free;
  assign accept      = bus.instr_valid_i && instr_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_reg <= 1'b0;
      alu_op_reg    <= '0;
      neg_mux_reg   <= 1'b0;
      imm_sel_reg   <= 1'b0;
      imm_reg       <= '0;
      rs1_reg       <= 5'd0;
      rs2_reg       <= 5'd0;
      rd_reg        <= 5'd0;
      regwrite_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (bus.flush_i) begin
      dec_valid_reg <= 1'b0;
    end else if (accept) begin
      dec_valid_reg <= 1'b1;
      alu_op_reg    <= alu_op_next;
      neg_mux_reg   <= neg_mux_next;
      imm_sel_reg   <= imm_sel_next;
      imm_reg       <= imm_next;
      rs1_reg       <= rs1_next;
      rs2_reg       <= bus.instr_i[24:20];
      rd_reg        <= rd_field;
      regwrite_reg  <= regwrite_next;
      illegal_reg   <= illegal_next;
    end else if (bus.dec_ready_i) begin
      dec_valid_reg <= 1'b0;
    end
  end

`ifdef MUL_EXT_EN
  logic [3:0] busy_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_cnt_reg <= 4'd0;
    end else if (bus.flush_i) begin
      busy_cnt_reg <= 4'd0;
    end else if (accept && is_mul_next) begin
      busy_cnt_reg <= 4'(MUL_LATENCY - 1);
    end else if (busy_cnt_reg != 4'd0) begin
      busy_cnt_reg <= busy_cnt_reg - 4'd1;
    end
  end

  assign busy_free = (busy_cnt_reg == 4'd0);
`else
  logic unused_is_mul;
  assign unused_is_mul = is_mul_next;
  assign busy_free     = 1'b1;
`endif

  assign bus.instr_ready_o   = instr_ready;
  assign bus.dec_valid_o     = dec_valid_reg;
  assign bus.alu_op_ctrl_o   = alu_op_reg;
  assign bus.neg_mux_ctrl_o  = neg_mux_reg;
  assign bus.imm_sel_o       = imm_sel_reg;
  assign bus.imm_o           = imm_reg;
  assign bus.rs1_addr_o      = rs1_reg;
  assign bus.rs2_addr_o      = rs2_reg;
  assign bus.rd_addr_o       = rd_reg;
  assign bus.regwrite_en_o   = regwrite_reg;
  assign bus.illegal_instr_o = illegal_reg;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed self-checking bench for decode_ctrl_pipe; MUL expectations follow MUL_EXT_EN.
module tb_decode_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.WORD_WIDTH(32), .ALU_OP_WIDTH(4)) bus ();

  decode_ctrl_pipe #(
    .WORD_WIDTH  (32),
    .ALU_OP_WIDTH(4),
    .MUL_LATENCY (3)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  localparam logic [31:0] I_ADD    = 32'h002081B3;
  localparam logic [31:0] I_SUB    = 32'h402081B3;
  localparam logic [31:0] I_ADDI   = 32'hFFF00293;
  localparam logic [31:0] I_SRAI   = 32'h4032D293;
  localparam logic [31:0] I_LUI    = 32'h123452B7;
  localparam logic [31:0] I_BADOPC = 32'h0000007F;
  localparam logic [31:0] I_BADSLL = 32'h40009093;
  localparam logic [31:0] I_BADAND = 32'h4020F1B3;
  localparam logic [31:0] I_XOR    = 32'h0020C233;
  localparam logic [31:0] I_OR     = 32'h0020E2B3;
  localparam logic [31:0] I_AND    = 32'h0020F333;
  localparam logic [31:0] I_ADDX0  = 32'h00208033;
  localparam logic [31:0] I_MUL    = 32'h022081B3;

  task automatic drive(input logic v, input logic [31:0] w);
    bus.instr_valid_i = v;
    bus.instr_i       = w;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    $display("txn %-8s instr=%08h v=%0b rdy=%0b | dv=%0b alu=%0d neg=%0b isel=%0b imm=%08h rs1=%0d rs2=%0d rd=%0d we=%0b ill=%0b",
             tag, bus.instr_i, bus.instr_valid_i, bus.instr_ready_o, bus.dec_valid_o,
             bus.alu_op_ctrl_o, bus.neg_mux_ctrl_o, bus.imm_sel_o, bus.imm_o,
             bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o, bus.regwrite_en_o, bus.illegal_instr_o);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush_i = 1'b0;
    bus.dec_ready_i = 1'b1;
    drive(1'b1, I_ADD);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.instr_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready actual=%0b expected=0", bus.instr_ready_o); end
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("FAIL rst_dec_valid actual=%0b expected=0", bus.dec_valid_o); end
    checks++; if (bus.alu_op_ctrl_o !== 4'd0) begin failures++; $display("FAIL rst_alu actual=%0d expected=0", bus.alu_op_ctrl_o); end
    checks++; if (bus.imm_o !== 32'h0) begin failures++; $display("FAIL rst_imm actual=%08h expected=00000000", bus.imm_o); end
    checks++; if (bus.rd_addr_o !== 5'd0) begin failures++; $display("FAIL rst_rd actual=%0d expected=0", bus.rd_addr_o); end
    checks++; if (bus.regwrite_en_o !== 1'b0 || bus.illegal_instr_o !== 1'b0) begin failures++; $display("FAIL rst_we_ill actual=%0b%0b expected=00", bus.regwrite_en_o, bus.illegal_instr_o); end
    drive(1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL post_rst_ready actual=%0b expected=1", bus.instr_ready_o); end
  endtask

  task automatic test_op();
    drive(1'b1, I_ADD);
    step("add");
    checks++; if (bus.dec_valid_o !== 1'b1) begin failures++; $display("FAIL add_valid actual=%0b expected=1", bus.dec_valid_o); end
    checks++; if (bus.alu_op_ctrl_o !== 4'd0) begin failures++; $display("FAIL add_alu actual=%0d expected=0", bus.alu_op_ctrl_o); end
    checks++; if (bus.rd_addr_o !== 5'd3 || bus.rs1_addr_o !== 5'd1 || bus.rs2_addr_o !== 5'd2) begin failures++; $display("FAIL add_regs actual=%0d/%0d/%0d expected=3/1/2", bus.rd_addr_o, bus.rs1_addr_o, bus.rs2_addr_o); end
    checks++; if (bus.regwrite_en_o !== 1'b1 || bus.imm_sel_o !== 1'b0 || bus.neg_mux_ctrl_o !== 1'b0) begin failures++; $display("FAIL add_ctl actual=we%0b isel%0b neg%0b expected=we1 isel0 neg0", bus.regwrite_en_o, bus.imm_sel_o, bus.neg_mux_ctrl_o); end
    drive(1'b1, I_SUB);
    step("sub");
    checks++; if (bus.alu_op_ctrl_o !== 4'd1 || bus.neg_mux_ctrl_o !== 1'b1) begin failures++; $display("FAIL sub_alu_neg actual=%0d/%0b expected=1/1", bus.alu_op_ctrl_o, bus.neg_mux_ctrl_o); end
  endtask

  task automatic test_imm();
    drive(1'b1, I_ADDI);
    step("addi");
    checks++; if (bus.imm_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_imm actual=%08h expected=ffffffff", bus.imm_o); end
    checks++; if (bus.imm_sel_o !== 1'b1 || bus.alu_op_ctrl_o !== 4'd0 || bus.neg_mux_ctrl_o !== 1'b0) begin failures++; $display("FAIL addi_ctl actual=isel%0b alu%0d neg%0b expected=isel1 alu0 neg0", bus.imm_sel_o, bus.alu_op_ctrl_o, bus.neg_mux_ctrl_o); end
    checks++; if (bus.rd_addr_o !== 5'd5 || bus.rs1_addr_o !== 5'd0 || bus.regwrite_en_o !== 1'b1) begin failures++; $display("FAIL addi_regs actual=rd%0d rs1%0d we%0b expected=rd5 rs10 we1", bus.rd_addr_o, bus.rs1_addr_o, bus.regwrite_en_o); end
    drive(1'b1, I_SRAI);
    step("srai");
    checks++; if (bus.alu_op_ctrl_o !== 4'd7 || bus.illegal_instr_o !== 1'b0) begin failures++; $display("FAIL srai_alu actual=%0d ill%0b expected=7 ill0", bus.alu_op_ctrl_o, bus.illegal_instr_o); end
    checks++; if (bus.imm_o !== 32'h00000403) begin failures++; $display("FAIL srai_imm actual=%08h expected=00000403", bus.imm_o); end
    drive(1'b1, I_LUI);
    step("lui");
    checks++; if (bus.imm_o !== 32'h12345000 || bus.imm_sel_o !== 1'b1) begin failures++; $display("FAIL lui_imm actual=%08h isel%0b expected=12345000 isel1", bus.imm_o, bus.imm_sel_o); end
    checks++; if (bus.rs1_addr_o !== 5'd0 || bus.alu_op_ctrl_o !== 4'd0 || bus.regwrite_en_o !== 1'b1) begin failures++; $display("FAIL lui_ctl actual=rs1%0d alu%0d we%0b expected=rs10 alu0 we1", bus.rs1_addr_o, bus.alu_op_ctrl_o, bus.regwrite_en_o); end
    drive(1'b1, I_BADOPC);
    step("badopc");
    checks++; if (bus.illegal_instr_o !== 1'b1 || bus.regwrite_en_o !== 1'b0 || bus.dec_valid_o !== 1'b1) begin failures++; $display("FAIL badopc actual=ill%0b we%0b dv%0b expected=ill1 we0 dv1", bus.illegal_instr_o, bus.regwrite_en_o, bus.dec_valid_o); end
    drive(1'b1, I_BADSLL);
    step("badslli");
    checks++; if (bus.illegal_instr_o !== 1'b1 || bus.regwrite_en_o !== 1'b0) begin failures++; $display("FAIL badslli actual=ill%0b we%0b expected=ill1 we0", bus.illegal_instr_o, bus.regwrite_en_o); end
    drive(1'b1, I_BADAND);
    step("badand");
    checks++; if (bus.illegal_instr_o !== 1'b1 || bus.alu_op_ctrl_o !== 4'd0) begin failures++; $display("FAIL badand actual=ill%0b alu%0d expected=ill1 alu0", bus.illegal_instr_o, bus.alu_op_ctrl_o); end
    drive(1'b0, 32'h0);
    step("drain");
    checks++; if (bus.dec_valid_o !== 1'b0 || bus.illegal_instr_o !== 1'b1) begin failures++; $display("FAIL drain_hold actual=dv%0b ill%0b expected=dv0 ill1", bus.dec_valid_o, bus.illegal_instr_o); end
  endtask

  task automatic test_backpressure();
    bus.dec_ready_i = 1'b0;
    drive(1'b1, I_ADD);
    step("bp_load");
    drive(1'b1, I_XOR);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      checks++; if (bus.instr_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready%0d actual=%0b expected=0", i, bus.instr_ready_o); end
      checks++; if (bus.dec_valid_o !== 1'b1 || bus.rd_addr_o !== 5'd3 || bus.alu_op_ctrl_o !== 4'd0) begin failures++; $display("FAIL bp_stable%0d actual=dv%0b rd%0d alu%0d expected=dv1 rd3 alu0", i, bus.dec_valid_o, bus.rd_addr_o, bus.alu_op_ctrl_o); end
    end
    bus.dec_ready_i = 1'b1;
    #1;
    checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready actual=%0b expected=1", bus.instr_ready_o); end
    step("xor");
    checks++; if (bus.dec_valid_o !== 1'b1 || bus.alu_op_ctrl_o !== 4'd2 || bus.rd_addr_o !== 5'd4) begin failures++; $display("FAIL stream_xor actual=dv%0b alu%0d rd%0d expected=dv1 alu2 rd4", bus.dec_valid_o, bus.alu_op_ctrl_o, bus.rd_addr_o); end
    drive(1'b1, I_OR);
    step("or");
    checks++; if (bus.dec_valid_o !== 1'b1 || bus.alu_op_ctrl_o !== 4'd3 || bus.rd_addr_o !== 5'd5) begin failures++; $display("FAIL stream_or actual=dv%0b alu%0d rd%0d expected=dv1 alu3 rd5", bus.dec_valid_o, bus.alu_op_ctrl_o, bus.rd_addr_o); end
    drive(1'b1, I_AND);
    step("and");
    checks++; if (bus.dec_valid_o !== 1'b1 || bus.alu_op_ctrl_o !== 4'd4 || bus.rd_addr_o !== 5'd6) begin failures++; $display("FAIL stream_and actual=dv%0b alu%0d rd%0d expected=dv1 alu4 rd6", bus.dec_valid_o, bus.alu_op_ctrl_o, bus.rd_addr_o); end
    drive(1'b0, 32'h0);
    step("idle");
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("FAIL stream_end_valid actual=%0b expected=0", bus.dec_valid_o); end
  endtask

  task automatic test_flush();
    bus.dec_ready_i = 1'b1;
    drive(1'b1, I_ADD);
    bus.flush_i = 1'b1;
    step("flush_acc");
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("FAIL flush_accept actual=%0b expected=0", bus.dec_valid_o); end
    bus.flush_i = 1'b0;
    bus.dec_ready_i = 1'b0;
    drive(1'b1, I_ADDI);
    step("hold");
    drive(1'b0, 32'h0);
    bus.flush_i = 1'b1;
    step("flush_hld");
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("FAIL flush_held actual=%0b expected=0", bus.dec_valid_o); end
    bus.flush_i = 1'b0;
    bus.dec_ready_i = 1'b1;
    drive(1'b1, I_ADDX0);
    step("add_x0");
    checks++; if (bus.dec_valid_o !== 1'b1 || bus.regwrite_en_o !== 1'b0 || bus.illegal_instr_o !== 1'b0 || bus.rd_addr_o !== 5'd0) begin failures++; $display("FAIL add_x0 actual=dv%0b we%0b ill%0b rd%0d expected=dv1 we0 ill0 rd0", bus.dec_valid_o, bus.regwrite_en_o, bus.illegal_instr_o, bus.rd_addr_o); end
    drive(1'b0, 32'h0);
    step("idle");
  endtask

  task automatic test_async_reset();
    drive(1'b1, I_ADD);
    step("pre_rst");
    drive(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dec_valid_o !== 1'b0 || bus.instr_ready_o !== 1'b0) begin failures++; $display("FAIL async_rst actual=dv%0b rdy%0b expected=dv0 rdy0", bus.dec_valid_o, bus.instr_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_mul();
    bus.dec_ready_i = 1'b1;
    drive(1'b1, I_MUL);
    step("mul");
`ifdef MUL_EXT_EN
    checks++; if (bus.alu_op_ctrl_o !== 4'd10 || bus.illegal_instr_o !== 1'b0 || bus.dec_valid_o !== 1'b1) begin failures++; $display("FAIL mul_dec actual=alu%0d ill%0b dv%0b expected=alu10 ill0 dv1", bus.alu_op_ctrl_o, bus.illegal_instr_o, bus.dec_valid_o); end
    checks++; if (bus.instr_ready_o !== 1'b0) begin failures++; $display("FAIL mul_busy1 actual=%0b expected=0", bus.instr_ready_o); end
    drive(1'b1, I_ADD);
    step("mul_bsy");
    checks++; if (bus.instr_ready_o !== 1'b0 || bus.dec_valid_o !== 1'b0) begin failures++; $display("FAIL mul_busy2 actual=rdy%0b dv%0b expected=rdy0 dv0", bus.instr_ready_o, bus.dec_valid_o); end
    step("mul_done");
    checks++; if (bus.instr_ready_o !== 1'b1 || bus.dec_valid_o !== 1'b0) begin failures++; $display("FAIL mul_free actual=rdy%0b dv%0b expected=rdy1 dv0", bus.instr_ready_o, bus.dec_valid_o); end
    step("add");
    checks++; if (bus.dec_valid_o !== 1'b1 || bus.alu_op_ctrl_o !== 4'd0) begin failures++; $display("FAIL mul_next actual=dv%0b alu%0d expected=dv1 alu0", bus.dec_valid_o, bus.alu_op_ctrl_o); end
`else
    checks++; if (bus.illegal_instr_o !== 1'b1 || bus.regwrite_en_o !== 1'b0 || bus.alu_op_ctrl_o !== 4'd0) begin failures++; $display("FAIL mul_illegal actual=ill%0b we%0b alu%0d expected=ill1 we0 alu0", bus.illegal_instr_o, bus.regwrite_en_o, bus.alu_op_ctrl_o); end
    checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL mul_nostall actual=%0b expected=1", bus.instr_ready_o); end
`endif
    drive(1'b0, 32'h0);
    step("idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_op();
    test_imm();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
